// File: rtl/typepkg.sv
// Shared types for the fetch stage: the {pc, insn} packet carried through fetch queues
// and the default reset fetch address.
package typepkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch packets, DEPTH a power of two >= 2. Head is visible combinationally;
// push and pop may coincide when full. Flush empties the queue in one cycle.
module fetch_queue
  import typepkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_pkt_t                 wdata,
  input  logic                       pop,
  output fetch_pkt_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: in-order word requests, queued responses toward decode (response->out_valid 1 cycle).
// Requests stall once buffered plus in-flight words reach QDEPTH; a redirect flushes and drops stale responses.
module ifetch
  import typepkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [CW:0]   tag_count;
  logic          req_hs;
  logic          resp_drop;
  logic          resp_keep;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic          tag_full;
  logic          tag_empty;
  fetch_pkt_t    q_wdata;
  fetch_pkt_t    q_head;
  fetch_pkt_t    tag_wdata;
  fetch_pkt_t    tag_head;
  logic          tag_unused;

  assign occupancy      = (CW+1)'(count) + (CW+1)'(inflight);
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // A response arriving with a redirect belongs to the abandoned stream as well.
  assign resp_drop = imem_resp_valid && (redirect_valid || (drop != '0));
  assign resp_keep = imem_resp_valid && !resp_drop;

  assign out_valid = (count != '0) && !redirect_valid;
  assign q_pop     = out_valid && out_ready;
  assign out_insn  = q_head.insn;
  assign out_pc    = q_head.pc;

  assign q_wdata   = '{pc: tag_head.pc, insn: imem_resp_data};
  assign tag_wdata = '{pc: pc, insn: 32'h0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= '0;
      drop     <= drop + inflight + CW'(req_hs) - CW'(imem_resp_valid);
    end else begin
      if (req_hs) pc <= pc + 32'd4;
      inflight <= inflight + CW'(req_hs) - CW'(resp_keep);
      drop     <= drop - CW'(resp_drop);
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_outq (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (resp_keep),
    .wdata (q_wdata),
    .pop   (q_pop),
    .head  (q_head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Tags cover dropped and live requests alike, so this FIFO survives a redirect.
  fetch_queue #(.DEPTH(2 * QDEPTH)) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_hs),
    .wdata (tag_wdata),
    .pop   (imem_resp_valid),
    .head  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign tag_unused = ^{tag_head.insn, tag_count, tag_full, tag_empty, q_full, q_empty};

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with an in-order memory model of programmable latency.
module tb_ifetch;
  import typepkg::*;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic [31:0] out_pc;

  ifetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_insn        (out_insn),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_req = 0;
  logic        r_rst = 1'b1;
  logic        o_rdy = 1'b1;
  logic        m_rdy = 1'b1;
  logic        r_vld = 1'b0;
  logic [31:0] r_pc = 32'h0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        s_req_v, s_out_v;
  logic [31:0] s_req_addr, s_out_pc, s_out_insn;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample mid-cycle, update memory model.
  task automatic step();
    @(negedge clk);
    rst            = r_rst;
    out_ready      = o_rdy;
    imem_req_ready = m_rdy;
    redirect_valid = r_vld;
    redirect_pc    = r_pc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (r_rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    #1;
    s_req_v    = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_out_v    = out_valid;
    s_out_pc   = out_pc;
    s_out_insn = out_insn;
    if (!r_rst && imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
      n_req++;
    end
    if (out_valid && out_ready) begin
      chk("stream_pc", out_pc, exp_pc);
      chk("stream_insn", out_insn, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (r_vld) exp_pc = {r_pc[31:2], 2'b00};
    cyc++;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_req_valid", 32'(s_req_v), 32'd0);
    chk("rst_req_addr", s_req_addr, RPC);
    chk("rst_out_valid", 32'(s_out_v), 32'd0);
    chk("rst_out_pc", s_out_pc, 32'h0);
    chk("rst_out_insn", s_out_insn, 32'h0);

    // Streaming, latency 1
    r_rst = 1'b0; cyc = 1; exp_pc = RPC;
    step();
    chk("c1_req_valid", 32'(s_req_v), 32'd1);
    chk("c1_req_addr", s_req_addr, 32'h0);
    chk("c1_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("c2_req_addr", s_req_addr, 32'h4);
    chk("c2_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("c3_req_addr", s_req_addr, 32'h8);
    chk("c3_out_valid", 32'(s_out_v), 32'd1);
    chk("c3_out_pc", s_out_pc, 32'h0);
    step();
    chk("c4_out_pc", s_out_pc, 32'h4);
    step();
    chk("c5_out_pc", s_out_pc, 32'h8);

    // Redirect coinciding with a response, unaligned target
    r_vld = 1'b1; r_pc = 32'h0000_0203;
    step();
    r_vld = 1'b0;
    chk("redir_req_valid", 32'(s_req_v), 32'd0);
    chk("redir_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("redir_t1_req_valid", 32'(s_req_v), 32'd1);
    chk("redir_t1_addr", s_req_addr, 32'h200);
    chk("redir_t1_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("redir_t2_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("redir_t3_out_valid", 32'(s_out_v), 32'd1);
    chk("redir_t3_out_pc", s_out_pc, 32'h200);

    // PC wrap
    r_vld = 1'b1; r_pc = 32'hFFFF_FFFC;
    step();
    r_vld = 1'b0;
    step();
    chk("wrap_addr0", s_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", s_req_addr, 32'h0);
    step();
    chk("wrap_out0", s_out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_out1", s_out_pc, 32'h0);

    // Reset asserted mid-stream
    r_rst = 1'b1;
    step();
    chk("midrst_req_valid", 32'(s_req_v), 32'd0);
    chk("midrst_req_addr", s_req_addr, RPC);
    chk("midrst_out_valid", 32'(s_out_v), 32'd0);
    chk("midrst_out_pc", s_out_pc, 32'h0);
    chk("midrst_out_insn", s_out_insn, 32'h0);
    step();

    // Decode stalled for 10 cycles, then released
    o_rdy = 1'b0; r_rst = 1'b0; cyc = 1; exp_pc = RPC; n_req = 0;
    repeat (5) step();
    chk("stall_hold_pc", s_out_pc, 32'h0);
    repeat (5) step();
    chk("stall_req_count", 32'(n_req), 32'(QD));
    chk("stall_req_valid", 32'(s_req_v), 32'd0);
    chk("stall_out_valid", 32'(s_out_v), 32'd1);
    chk("stall_out_pc", s_out_pc, 32'h0);
    o_rdy = 1'b1;
    repeat (12) step();
    chk("resume_next_pc", exp_pc, 32'h30);

    // Latency 3, redirect with two requests in flight
    r_rst = 1'b1;
    step();
    r_rst = 1'b0; lat = 3; cyc = 1; exp_pc = RPC;
    step();
    step();
    r_vld = 1'b1; r_pc = 32'h0000_0100;
    step();
    r_vld = 1'b0;
    chk("l3_redir_req_valid", 32'(s_req_v), 32'd0);
    step();
    chk("l3_t1_req_valid", 32'(s_req_v), 32'd1);
    chk("l3_t1_addr", s_req_addr, 32'h100);
    chk("l3_t1_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("l3_t2_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("l3_t3_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("l3_t4_out_valid", 32'(s_out_v), 32'd0);
    step();
    chk("l3_t5_out_valid", 32'(s_out_v), 32'd1);
    chk("l3_t5_out_pc", s_out_pc, 32'h100);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
